// File: rtl/bit_serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, one full-subtractor cell plus a borrow flop; WIDTH+2 cycles per op.
// Define SUB_OVF_EN to add the registered signed-overflow output ovf.
module bit_serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
`ifdef SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_next;
   logic [WIDTH-1:0] sa, sb, res;
   logic             br;
   logic [CW-1:0]    cnt;
   logic             d, br_next, last_bit;

   // Full-subtractor cell on the current LSBs
   assign d        = sa[0] ^ sb[0] ^ br;
   assign br_next  = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
   assign last_bit = (cnt == LAST);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: if (start) state_next = RUN;
         RUN: begin
            busy = 1'b1;
            if (last_bit) state_next = DONE;
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sa   <= '0;
         sb   <= '0;
         res  <= '0;
         br   <= 1'b0;
         cnt  <= '0;
         diff <= '0;
         bout <= 1'b0;
`ifdef SUB_OVF_EN
         ovf  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (start) begin
               sa  <= a;
               sb  <= b;
               br  <= bin;
               cnt <= '0;
            end
            RUN: begin
               sa  <= {1'b0, sa[WIDTH-1:1]};
               sb  <= {1'b0, sb[WIDTH-1:1]};
               res <= {d, res[WIDTH-1:1]};
               br  <= br_next;
               cnt <= cnt + CW'(1);
               if (last_bit) begin
                  diff <= {d, res[WIDTH-1:1]};
                  bout <= br_next;
`ifdef SUB_OVF_EN
                  // On the final bit sa[0]/sb[0] are the latched operand MSBs
                  ovf  <= (sa[0] != sb[0]) && (d != sa[0]);
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule
